decode_stage: RTL and testbench

- Registered, handshaked instruction-decode stage for the MIPS core; the successor to the combinational decoder.
- Takes fetched instruction words over a valid/ready interface and emits a registered control bundle to the execute stage.
- Detects load-use hazards and sequences a multi-cycle MULTU, stalling dependent instructions.
- Flags unsupported encodings instead of driving X.

---
 rtl/decode_stage_if.sv | 32 +++
 rtl/decode_stage.sv | 226 ++++++++++++++++++++++
 tb/tb_decode_stage.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/decode_stage_if.sv
// Valid/ready bundle between fetch, the decode stage and execute.
// The master modport is the fetch/execute side; the slave modport is the decode stage.
interface decode_stage_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic        out_valid;
    logic        out_ready;
    logic        memtoreg;
    logic        memwrite;
    logic [1:0]  branchkind;
    logic        alusrcbimm;
    logic [4:0]  destreg;
    logic        regwrite;
    logic        dojump;
    logic        dojumpreg;
    logic [2:0]  alucontrol;
    logic        illegal;
    logic        mul_busy;

    modport master (
        output in_valid, instr, out_ready,
        input  in_ready, out_valid, memtoreg, memwrite, branchkind, alusrcbimm,
               destreg, regwrite, dojump, dojumpreg, alucontrol, illegal, mul_busy
    );

    modport slave (
        input  in_valid, instr, out_ready,
        output in_ready, out_valid, memtoreg, memwrite, branchkind, alusrcbimm,
               destreg, regwrite, dojump, dojumpreg, alucontrol, illegal, mul_busy
    );
endinterface

// File: rtl/decode_stage.sv
// Registered MIPS decode stage: valid/ready in and out, load-use interlock and
// a MULTU busy sequencer that holds back dependent HI/LO accesses.
module decode_stage #(
    parameter int unsigned MUL_CYCLES       = 4,
    parameter bit          ENABLE_MULT      = 1'b1,
    parameter int unsigned LOAD_USE_BUBBLES = 1
) (
    input logic          clk,
    input logic          reset,
    decode_stage_if.slave bus
);
    typedef struct packed {
        logic       memtoreg;
        logic       memwrite;
        logic [1:0] branchkind;
        logic       alusrcbimm;
        logic [4:0] destreg;
        logic       regwrite;
        logic       dojump;
        logic       dojumpreg;
        logic [2:0] alucontrol;
        logic       illegal;
    } ctrl_t;

    localparam logic [5:0] OpRtype = 6'b000000;
    localparam logic [5:0] OpBltz  = 6'b000001;
    localparam logic [5:0] OpJ     = 6'b000010;
    localparam logic [5:0] OpJal   = 6'b000011;
    localparam logic [5:0] OpBeq   = 6'b000100;
    localparam logic [5:0] OpAddiu = 6'b001001;
    localparam logic [5:0] OpOri   = 6'b001101;
    localparam logic [5:0] OpLui   = 6'b001111;
    localparam logic [5:0] OpLw    = 6'b100011;
    localparam logic [5:0] OpSw    = 6'b101011;

    localparam logic [5:0] FnJr    = 6'b001000;
    localparam logic [5:0] FnMfhi  = 6'b010000;
    localparam logic [5:0] FnMflo  = 6'b010010;
    localparam logic [5:0] FnMultu = 6'b011001;
    localparam logic [5:0] FnAddu  = 6'b100001;
    localparam logic [5:0] FnSubu  = 6'b100011;
    localparam logic [5:0] FnAnd   = 6'b100100;
    localparam logic [5:0] FnOr    = 6'b100101;
    localparam logic [5:0] FnSltu  = 6'b101011;

    logic [5:0] op, funct;
    logic [4:0] rs, rt, rd;
    logic       unused_shamt;

    assign op           = bus.instr[31:26];
    assign rs           = bus.instr[25:21];
    assign rt           = bus.instr[20:16];
    assign rd           = bus.instr[15:11];
    assign funct        = bus.instr[5:0];
    assign unused_shamt = ^bus.instr[10:6];

    ctrl_t dec;
    logic  is_mult, is_multu, reads_rs, reads_rt;

    always_comb begin
        dec      = '0;
        is_mult  = 1'b0;
        is_multu = 1'b0;
        reads_rs = 1'b1;
        reads_rt = 1'b0;
        case (op)
            OpRtype: begin
                reads_rt     = 1'b1;
                dec.regwrite = 1'b1;
                dec.destreg  = rd;
                case (funct)
                    FnAddu:  dec.alucontrol = 3'b101;
                    FnSubu:  dec.alucontrol = 3'b001;
                    FnAnd:   dec.alucontrol = 3'b111;
                    FnOr:    dec.alucontrol = 3'b110;
                    FnSltu:  dec.alucontrol = 3'b000;
                    FnJr: begin
                        dec.alucontrol = 3'b101;
                        dec.regwrite   = 1'b0;
                        dec.destreg    = '0;
                        dec.dojumpreg  = 1'b1;
                    end
                    FnMultu: begin
                        dec.alucontrol = 3'b100;
                        dec.regwrite   = 1'b0;
                        dec.destreg    = '0;
                        is_mult        = ENABLE_MULT;
                        is_multu       = ENABLE_MULT;
                        dec.illegal    = !ENABLE_MULT;
                    end
                    FnMfhi, FnMflo: begin
                        dec.alucontrol = 3'b101;
                        is_mult        = ENABLE_MULT;
                        dec.illegal    = !ENABLE_MULT;
                    end
                    default: dec.illegal = 1'b1;
                endcase
            end
            OpLw: begin
                dec.alucontrol = 3'b101;
                dec.alusrcbimm = 1'b1;
                dec.destreg    = rt;
                dec.regwrite   = 1'b1;
                dec.memtoreg   = 1'b1;
            end
            OpSw: begin
                reads_rt       = 1'b1;
                dec.alucontrol = 3'b101;
                dec.alusrcbimm = 1'b1;
                dec.destreg    = rt;
                dec.memwrite   = 1'b1;
            end
            OpBeq: begin
                reads_rt       = 1'b1;
                dec.alucontrol = 3'b001;
                dec.branchkind = 2'b01;
            end
            OpBltz: begin
                dec.alucontrol = 3'b010;
                dec.branchkind = 2'b10;
            end
            OpAddiu, OpOri: begin
                dec.alucontrol = (op == OpOri) ? 3'b110 : 3'b101;
                dec.alusrcbimm = 1'b1;
                dec.destreg    = rt;
                dec.regwrite   = 1'b1;
            end
            OpLui: begin
                reads_rs       = 1'b0;
                dec.alucontrol = 3'b011;
                dec.alusrcbimm = 1'b1;
                dec.destreg    = rt;
                dec.regwrite   = 1'b1;
            end
            OpJ: begin
                reads_rs       = 1'b0;
                dec.alucontrol = 3'b010;
                dec.dojump     = 1'b1;
            end
            OpJal: begin
                reads_rs       = 1'b0;
                dec.alucontrol = 3'b101;
                dec.dojump     = 1'b1;
                dec.regwrite   = 1'b1;
                dec.destreg    = 5'd31;
            end
            default: dec.illegal = 1'b1;
        endcase
        // Illegal encodings issue with every side effect suppressed.
        if (dec.illegal) begin
            dec         = '0;
            dec.illegal = 1'b1;
        end
    end

    ctrl_t      ctrl_q;
    logic       out_valid_q, out_valid_d;
    logic [3:0] mul_cnt_q, mul_cnt_d;
    logic [1:0] lu_cnt_q, lu_cnt_d;
    logic [4:0] lu_dest_q, lu_dest_d;
    logic       in_fire, out_fire, lw_in_out, hit_out, hit_cnt, stall;

    assign in_fire  = bus.in_valid & bus.in_ready;
    assign out_fire = out_valid_q & bus.out_ready;

    // A LW still in the output register counts as armed before its bubble count starts.
    assign lw_in_out = out_valid_q & ctrl_q.memtoreg & (ctrl_q.destreg != 5'd0);
    assign hit_out   = (ctrl_q.destreg != 5'd0) &
                       ((reads_rs & (rs == ctrl_q.destreg)) | (reads_rt & (rt == ctrl_q.destreg)));
    assign hit_cnt   = (lu_dest_q != 5'd0) &
                       ((reads_rs & (rs == lu_dest_q)) | (reads_rt & (rt == lu_dest_q)));

    assign stall = bus.in_valid & ((is_mult & (mul_cnt_q != 4'd0)) |
                                   (lw_in_out & hit_out) |
                                   ((lu_cnt_q != 2'd0) & hit_cnt));

    assign bus.in_ready = reset & (!out_valid_q | bus.out_ready) & !stall;

    always_comb begin
        out_valid_d = out_valid_q;
        if (in_fire)       out_valid_d = 1'b1;
        else if (out_fire) out_valid_d = 1'b0;

        mul_cnt_d = mul_cnt_q;
        if (in_fire & is_multu)     mul_cnt_d = 4'(MUL_CYCLES);
        else if (mul_cnt_q != 4'd0) mul_cnt_d = mul_cnt_q - 4'd1;

        lu_cnt_d  = lu_cnt_q;
        lu_dest_d = lu_dest_q;
        if (out_fire & lw_in_out) begin
            lu_cnt_d  = 2'(LOAD_USE_BUBBLES);
            lu_dest_d = ctrl_q.destreg;
        end else if (lu_cnt_q != 2'd0) begin
            lu_cnt_d = lu_cnt_q - 2'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ctrl_q      <= '0;
            out_valid_q <= 1'b0;
            mul_cnt_q   <= '0;
            lu_cnt_q    <= '0;
            lu_dest_q   <= '0;
        end else begin
            if (in_fire) ctrl_q <= dec;
            out_valid_q <= out_valid_d;
            mul_cnt_q   <= mul_cnt_d;
            lu_cnt_q    <= lu_cnt_d;
            lu_dest_q   <= lu_dest_d;
        end
    end

    assign bus.out_valid  = out_valid_q;
    assign bus.memtoreg   = ctrl_q.memtoreg;
    assign bus.memwrite   = ctrl_q.memwrite;
    assign bus.branchkind = ctrl_q.branchkind;
    assign bus.alusrcbimm = ctrl_q.alusrcbimm;
    assign bus.destreg    = ctrl_q.destreg;
    assign bus.regwrite   = ctrl_q.regwrite;
    assign bus.dojump     = ctrl_q.dojump;
    assign bus.dojumpreg  = ctrl_q.dojumpreg;
    assign bus.alucontrol = ctrl_q.alucontrol;
    assign bus.illegal    = ctrl_q.illegal;
    assign bus.mul_busy   = (mul_cnt_q != 4'd0);
endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: a default instance plus one built with ENABLE_MULT=0.
module tb_decode_stage;
    logic clk = 1'b0;
    logic reset;
    int   tests = 0;
    int   fails = 0;

    decode_stage_if bus ();
    decode_stage_if bus2 ();

    decode_stage #(.MUL_CYCLES(4), .ENABLE_MULT(1'b1), .LOAD_USE_BUBBLES(1)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    decode_stage #(.MUL_CYCLES(4), .ENABLE_MULT(1'b0), .LOAD_USE_BUBBLES(1)) dut2 (
        .clk  (clk),
        .reset(reset),
        .bus  (bus2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [21:0] all_out();
        return {bus.out_valid, bus.memtoreg, bus.memwrite, bus.branchkind, bus.alusrcbimm,
                bus.destreg, bus.regwrite, bus.dojump, bus.dojumpreg, bus.alucontrol,
                bus.illegal, bus.mul_busy};
    endfunction

    initial begin
        reset         = 1'b0;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        bus.instr     = 32'h2402_0005;   // ADDIU $2,$0,5
        bus2.in_valid  = 1'b0;
        bus2.out_ready = 1'b1;
        bus2.instr     = 32'h0;

        @(negedge clk);
        @(negedge clk);
        chk("reset_outputs", 32'(all_out()), 32'h0);
        chk("reset_in_ready", bus.in_ready, 1'b0);
        reset = 1'b1;
        #1 chk("post_reset_in_ready", bus.in_ready, 1'b1);

        @(negedge clk);
        chk("addiu_valid", bus.out_valid, 1'b1);
        chk("addiu_alu", bus.alucontrol, 3'b101);
        chk("addiu_imm", bus.alusrcbimm, 1'b1);
        chk("addiu_dest", bus.destreg, 5'd2);
        chk("addiu_regwrite", bus.regwrite, 1'b1);
        bus.instr = 32'h0041_1821;       // ADDU $3,$2,$1

        @(negedge clk);
        chk("addu_valid", bus.out_valid, 1'b1);
        chk("addu_dest", bus.destreg, 5'd3);
        chk("addu_alu", bus.alucontrol, 3'b101);
        chk("addu_imm", bus.alusrcbimm, 1'b0);
        bus.instr = 32'h0C00_0010;       // JAL

        @(negedge clk);
        chk("jal_valid", bus.out_valid, 1'b1);
        chk("jal_dojump", bus.dojump, 1'b1);
        chk("jal_dest", bus.destreg, 5'd31);
        chk("jal_regwrite", bus.regwrite, 1'b1);
        bus.in_valid = 1'b0;

        @(negedge clk);
        chk("drain_valid", bus.out_valid, 1'b0);

        // Dependent load-use pair.
        bus.in_valid = 1'b1;
        bus.instr    = 32'h8C22_0000;    // LW $2,0($1)
        #1 chk("lw_in_ready", bus.in_ready, 1'b1);
        @(negedge clk);
        chk("lw_memtoreg", bus.memtoreg, 1'b1);
        chk("lw_dest", bus.destreg, 5'd2);
        chk("lw_imm", bus.alusrcbimm, 1'b1);
        bus.instr = 32'h0044_1821;       // ADDU $3,$2,$4
        #1 chk("lu_stall_lw_held", bus.in_ready, 1'b0);
        @(negedge clk);
        chk("lu_lw_gone", bus.out_valid, 1'b0);
        chk("lu_bubble", bus.in_ready, 1'b0);
        @(negedge clk);
        chk("lu_release", bus.in_ready, 1'b1);
        @(negedge clk);
        chk("lu_addu_valid", bus.out_valid, 1'b1);
        chk("lu_addu_dest", bus.destreg, 5'd3);
        chk("lu_addu_memtoreg", bus.memtoreg, 1'b0);

        // Same shape, no dependency.
        bus.instr = 32'h8C22_0000;
        #1 chk("nodep_lw_ready", bus.in_ready, 1'b1);
        @(negedge clk);
        bus.instr = 32'h0085_1821;       // ADDU $3,$4,$5
        #1 chk("nodep_no_stall", bus.in_ready, 1'b1);
        @(negedge clk);
        chk("nodep_valid", bus.out_valid, 1'b1);
        chk("nodep_dest", bus.destreg, 5'd3);
        bus.in_valid = 1'b0;
        @(negedge clk);

        // MULTU, interleaved ORI, then MFLO waiting on mul_busy.
        bus.in_valid = 1'b1;
        bus.instr    = 32'h0022_0019;    // MULTU $1,$2
        #1 chk("multu_ready", bus.in_ready, 1'b1);
        @(negedge clk);
        chk("multu_alu", bus.alucontrol, 3'b100);
        chk("multu_regwrite", bus.regwrite, 1'b0);
        chk("mul_busy_1", bus.mul_busy, 1'b1);
        bus.instr = 32'h3406_0007;       // ORI $6,$0,7
        #1 chk("ori_no_stall", bus.in_ready, 1'b1);
        @(negedge clk);
        chk("ori_alu", bus.alucontrol, 3'b110);
        chk("ori_dest", bus.destreg, 5'd6);
        chk("mul_busy_2", bus.mul_busy, 1'b1);
        bus.instr = 32'h0000_2812;       // MFLO $5
        #1 chk("mflo_stall_2", bus.in_ready, 1'b0);
        @(negedge clk);
        chk("mul_busy_3", bus.mul_busy, 1'b1);
        chk("mflo_stall_3", bus.in_ready, 1'b0);
        @(negedge clk);
        chk("mul_busy_4", bus.mul_busy, 1'b1);
        chk("mflo_stall_4", bus.in_ready, 1'b0);
        @(negedge clk);
        chk("mul_busy_fall", bus.mul_busy, 1'b0);
        chk("mflo_ready", bus.in_ready, 1'b1);
        @(negedge clk);
        chk("mflo_alu", bus.alucontrol, 3'b101);
        chk("mflo_dest", bus.destreg, 5'd5);
        chk("mflo_regwrite", bus.regwrite, 1'b1);

        // Backpressure: MFLO held for three cycles, SUBU waits behind it.
        bus.out_ready = 1'b0;
        bus.instr     = 32'h0085_3823;   // SUBU $7,$4,$5
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_valid", bus.out_valid, 1'b1);
            chk("bp_dest_hold", bus.destreg, 5'd5);
            chk("bp_alu_hold", bus.alucontrol, 3'b101);
            chk("bp_in_ready", bus.in_ready, 1'b0);
        end
        bus.out_ready = 1'b1;
        #1 chk("bp_release_ready", bus.in_ready, 1'b1);
        @(negedge clk);
        chk("bp_next_valid", bus.out_valid, 1'b1);
        chk("bp_next_dest", bus.destreg, 5'd7);
        chk("bp_next_alu", bus.alucontrol, 3'b001);
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("bp_drained", bus.out_valid, 1'b0);

        // Illegal encodings and a few remaining opcodes.
        bus.in_valid = 1'b1;
        bus.instr    = 32'hFC00_0000;
        @(negedge clk);
        chk("ill_op_flag", bus.illegal, 1'b1);
        chk("ill_op_valid", bus.out_valid, 1'b1);
        chk("ill_op_side", {bus.regwrite, bus.memwrite, bus.dojump, bus.dojumpreg,
                            bus.branchkind}, 6'b0);
        bus.instr = 32'h0000_003F;
        @(negedge clk);
        chk("ill_fn_flag", bus.illegal, 1'b1);
        chk("ill_fn_side", {bus.regwrite, bus.memwrite, bus.dojump}, 3'b0);
        bus.instr = 32'h1022_0003;       // BEQ $1,$2
        @(negedge clk);
        chk("beq_kind", bus.branchkind, 2'b01);
        chk("beq_alu", bus.alucontrol, 3'b001);
        chk("beq_legal", bus.illegal, 1'b0);
        bus.instr = 32'hAC22_0004;       // SW $2,4($1)
        @(negedge clk);
        chk("sw_memwrite", bus.memwrite, 1'b1);
        chk("sw_regwrite", bus.regwrite, 1'b0);
        chk("sw_imm", bus.alusrcbimm, 1'b1);
        bus.in_valid = 1'b0;

        // Multiply ops disabled.
        bus2.in_valid = 1'b1;
        bus2.instr    = 32'h0022_0019;
        @(negedge clk);
        chk("nomult_valid", bus2.out_valid, 1'b1);
        chk("nomult_illegal", bus2.illegal, 1'b1);
        chk("nomult_busy", bus2.mul_busy, 1'b0);
        bus2.in_valid = 1'b0;

        // Reset in the middle of a MULTU.
        bus.in_valid = 1'b1;
        bus.instr    = 32'h0022_0019;
        @(negedge clk);
        chk("rst_mul_busy_pre", bus.mul_busy, 1'b1);
        bus.in_valid = 1'b0;
        #2 reset = 1'b0;
        #1 chk("rst_async_busy", bus.mul_busy, 1'b0);
        chk("rst_async_valid", bus.out_valid, 1'b0);
        @(negedge clk);
        reset        = 1'b1;
        bus.in_valid = 1'b1;
        bus.instr    = 32'h0000_2812;    // MFLO $5
        #1 chk("rst_mflo_ready", bus.in_ready, 1'b1);
        @(negedge clk);
        chk("rst_mflo_valid", bus.out_valid, 1'b1);
        chk("rst_mflo_dest", bus.destreg, 5'd5);
        bus.in_valid = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
